// File: rtl/nbcac_pkg.sv
// Shared constants and the crosstalk pair rule for the NBCAC link.
package nbcac_pkg;

   localparam int unsigned NBCAC_CODE_W = 23;
   localparam int unsigned NBCAC_DATA_W = 16;

   // Slices are {wire k+1, wire k}; adjacent wires toggling in opposite directions.
   function automatic logic is_forbidden_pair(input logic [1:0] prev2, input logic [1:0] cur2);
      return ((prev2 == 2'b10) && (cur2 == 2'b01)) || ((prev2 == 2'b01) && (cur2 == 2'b10));
   endfunction

endpackage

// File: rtl/nbcac_link_rx_23_if.sv
// Codeword bus with its valid qualifier; master drives, slave observes.
interface nbcac_link_rx_23_if
   import nbcac_pkg::*;
#(
   parameter int unsigned CODE_W = NBCAC_CODE_W
) ();

   logic [CODE_W:1] code;
   logic            code_valid;

   modport master (output code, output code_valid);
   modport slave  (input  code, input  code_valid);

endinterface

// File: rtl/nbcac_ftr_check.sv
// Combinational forbidden-transition detector over every adjacent wire pair.
module nbcac_ftr_check
   import nbcac_pkg::*;
#(
   parameter int unsigned CODE_W = NBCAC_CODE_W
) (
   input  logic [CODE_W:1]   i_prev,
   input  logic [CODE_W:1]   i_cur,
   output logic [CODE_W-1:1] o_pair_hit
);

   always_comb begin
      o_pair_hit = '0;
      for (int k = 1; k < int'(CODE_W); k++) begin
         o_pair_hit[k] = is_forbidden_pair({i_prev[k+1], i_prev[k]}, {i_cur[k+1], i_cur[k]});
      end
   end

endmodule

// File: rtl/nbcac_link_rx_23.sv
// Receive front end: registers the link codeword and tracks crosstalk-forbidden transitions
// between consecutive valid words.
module nbcac_link_rx_23
   import nbcac_pkg::*;
#(
   parameter int unsigned CODE_W = NBCAC_CODE_W,
   parameter int unsigned CNT_W  = NBCAC_DATA_W
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                clr,
   nbcac_link_rx_23_if.slave   link_in,
   nbcac_link_rx_23_if.master  link_out,
   output logic                ftr_flag,
   output logic [CNT_W-1:0]    viol_count,
   output logic [CODE_W-1:1]   viol_pair_mask
);

   logic [CODE_W:1]   r_codeout;
   logic              r_code_valid;
   logic              r_ftr_flag;
   logic [CNT_W-1:0]  r_viol_count;
   logic [CODE_W-1:1] r_viol_pair_mask;
   logic [CODE_W:1]   r_prev_word;
   logic              r_hist_valid;

   logic [CODE_W-1:1] w_raw_hit;
   logic [CODE_W-1:1] w_pair_hit;
   logic              w_any_hit;
   logic              w_check_en;

   nbcac_ftr_check #(
      .CODE_W (CODE_W)
   ) u_ftr_check (
      .i_prev     (r_prev_word),
      .i_cur      (link_in.code),
      .o_pair_hit (w_raw_hit)
   );

   assign w_check_en = r_hist_valid & link_in.code_valid;
   assign w_pair_hit = w_raw_hit & {(CODE_W-1){w_check_en}};
   assign w_any_hit  = |w_pair_hit;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_codeout        <= '0;
         r_code_valid     <= 1'b0;
         r_ftr_flag       <= 1'b0;
         r_viol_count     <= '0;
         r_viol_pair_mask <= '0;
         r_prev_word      <= '0;
         r_hist_valid     <= 1'b0;
      end else begin
         r_code_valid <= link_in.code_valid;
         if (link_in.code_valid) begin
            r_codeout    <= link_in.code;
            r_prev_word  <= link_in.code;
            r_hist_valid <= 1'b1;
         end
         // A word arriving with clr still seeds the history, but is neither flagged nor counted.
         if (clr) begin
            r_ftr_flag       <= 1'b0;
            r_viol_count     <= '0;
            r_viol_pair_mask <= '0;
            if (!link_in.code_valid) begin
               r_hist_valid <= 1'b0;
            end
         end else begin
            r_ftr_flag       <= w_any_hit;
            r_viol_pair_mask <= r_viol_pair_mask | w_pair_hit;
            if (w_any_hit && (r_viol_count != {CNT_W{1'b1}})) begin
               r_viol_count <= r_viol_count + CNT_W'(1);
            end
         end
      end
   end

   assign link_out.code       = r_codeout;
   assign link_out.code_valid = r_code_valid;
   assign ftr_flag            = r_ftr_flag;
   assign viol_count          = r_viol_count;
   assign viol_pair_mask      = r_viol_pair_mask;

endmodule

// File: tb/tb_nbcac_link_rx_23.sv
// Scoreboard bench: directed words push hand-computed responses; a negedge monitor checks them.
module tb_nbcac_link_rx_23;

   logic clock;
   logic rst_n;
   logic clr;

   nbcac_link_rx_23_if link_in ();
   nbcac_link_rx_23_if out16 ();
   nbcac_link_rx_23_if out4 ();

   logic        flag16, flag4;
   logic [15:0] cnt16;
   logic [3:0]  cnt4;
   logic [22:1] mask16, mask4;

   nbcac_link_rx_23 dut (
      .clock          (clock),
      .rst_n          (rst_n),
      .clr            (clr),
      .link_in        (link_in),
      .link_out       (out16),
      .ftr_flag       (flag16),
      .viol_count     (cnt16),
      .viol_pair_mask (mask16)
   );

   nbcac_link_rx_23 #(
      .CNT_W (4)
   ) dut_sat (
      .clock          (clock),
      .rst_n          (rst_n),
      .clr            (clr),
      .link_in        (link_in),
      .link_out       (out4),
      .ftr_flag       (flag4),
      .viol_count     (cnt4),
      .viol_pair_mask (mask4)
   );

   typedef struct {
      logic [22:0] code;
      logic        flag;
      int          cnt;
      logic [21:0] mask;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   logic [22:0] last_code = '0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " codeout"}, 32'(out16.code), 32'h0);
      chk({tag, " valid"}, 32'(out16.code_valid), 32'h0);
      chk({tag, " flag"}, 32'(flag16), 32'h0);
      chk({tag, " count"}, 32'(cnt16), 32'h0);
      chk({tag, " mask"}, 32'(mask16), 32'h0);
      chk({tag, " count4"}, 32'(cnt4), 32'h0);
      chk({tag, " mask4"}, 32'(mask4), 32'h0);
   endtask

   task automatic send(input logic [22:0] w, input logic f, input int c, input logic [21:0] m,
                       input logic do_clr);
      exp_t e;
      e.code = w;
      e.flag = f;
      e.cnt  = c;
      e.mask = m;
      q.push_back(e);
      link_in.code       = w;
      link_in.code_valid = 1'b1;
      clr                = do_clr;
      @(posedge clock);
      #1;
      link_in.code_valid = 1'b0;
      clr                = 1'b0;
   endtask

   task automatic idle(input int n);
      link_in.code_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Monitor: pops on every forwarded word, otherwise checks the idle-cycle behaviour.
   always @(negedge clock) begin
      if (!rst_n) begin
         last_code = '0;
      end else if (out16.code_valid) begin
         if (q.size() == 0) begin
            chk("unexpected word", 32'(out16.code), 32'h7FFFFFFF);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("codeout", 32'(out16.code), 32'(e.code));
            chk("ftr_flag", 32'(flag16), 32'(e.flag));
            chk("viol_count", 32'(cnt16), 32'(e.cnt));
            chk("viol_pair_mask", 32'(mask16), 32'(e.mask));
            chk("sat valid", 32'(out4.code_valid), 32'h1);
            chk("sat ftr_flag", 32'(flag4), 32'(e.flag));
            chk("sat viol_count", 32'(cnt4), (e.cnt > 15) ? 32'd15 : 32'(e.cnt));
            chk("sat viol_pair_mask", 32'(mask4), 32'(e.mask));
            last_code = e.code;
         end
      end else begin
         chk("idle ftr_flag", 32'(flag16), 32'h0);
         chk("idle codeout hold", 32'(out16.code), 32'(last_code));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      rst_n              = 1'b0;
      clr                = 1'b0;
      link_in.code       = '0;
      link_in.code_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_reset("reset");
      rst_n = 1'b1;
      idle(1);

      // First word unchecked, then clear the history with an idle clr.
      send(23'h155555, 1'b0, 0, 22'h0, 1'b0);
      clr = 1'b1;
      idle(1);
      clr = 1'b0;

      // Single violation on pair 1, then legal sequences.
      send(23'h000001, 1'b0, 0, 22'h0, 1'b0);
      send(23'h000002, 1'b1, 1, 22'h000001, 1'b0);
      send(23'h000003, 1'b0, 1, 22'h000001, 1'b0);
      send(23'h000001, 1'b0, 1, 22'h000001, 1'b0);
      send(23'h000003, 1'b0, 1, 22'h000001, 1'b0);

      // Every pair swaps across an idle gap; one count, all mask bits.
      send(23'h2AAAAA, 1'b0, 1, 22'h000001, 1'b0);
      idle(3);
      send(23'h555555, 1'b1, 2, 22'h3FFFFF, 1'b0);

      // Saturation: the 4-bit instance stops at 15, the 16-bit one keeps counting.
      for (int i = 0; i < 20; i++) begin
         send((i % 2 == 0) ? 23'h2AAAAA : 23'h555555, 1'b1, 3 + i, 22'h3FFFFF, 1'b0);
      end

      // clr with a valid word: forwarded, unchecked, becomes the new history.
      send(23'h000001, 1'b0, 22, 22'h3FFFFF, 1'b0);
      send(23'h000002, 1'b0, 0, 22'h0, 1'b1);
      send(23'h000001, 1'b1, 1, 22'h000001, 1'b0);

      // Reset mid-stream with a word in flight.
      link_in.code       = 23'h7FFFFF;
      link_in.code_valid = 1'b1;
      @(posedge clock);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("mid reset");
      link_in.code_valid = 1'b0;
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      idle(1);

      // History lost: first word unchecked; next flags pairs 1..21 but not the top pair.
      send(23'h155555, 1'b0, 0, 22'h0, 1'b0);
      send(23'h2AAAAA, 1'b1, 1, 22'h1FFFFF, 1'b0);

      for (int i = 0; i < 20 && q.size() != 0; i++) begin
         @(posedge clock);
      end
      idle(2);
      chk("scoreboard drained", 32'(q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
